// File: rtl/acq_sequencer_pkg.sv
// Shared types and constants for the acquisition sequencer: state encodings,
// control-register bit positions and default register map values.
package acq_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        WAIT_TRIG = 3'd2,
        XFER_A    = 3'd3,
        XFER_B    = 3'd4,
        DONE      = 3'd5,
        HOLDOFF   = 3'd6
    } acq_state_e;

    localparam int unsigned CTRL_RUN  = 0;
    localparam int unsigned CTRL_CONT = 1;
    localparam int unsigned CTRL_AUTO = 2;
    localparam int unsigned CTRL_CHA  = 3;
    localparam int unsigned CTRL_CHB  = 4;
    localparam int unsigned CTRL_BITS = 5;

    localparam int unsigned ADDR_ACQ_CTRL_DEF    = 16;
    localparam int unsigned ADDR_HOLDOFF_DEF     = 17;
    localparam int unsigned DEFAULT_ACQ_CTRL_DEF = 0;
    localparam int unsigned DEFAULT_HOLDOFF_DEF  = 0;
    localparam int unsigned AUTO_TIMEOUT_DEF     = 10000000;

endpackage

// File: rtl/acq_sequencer_if.sv
// Registers-bus write port feeding the acquisition sequencer.
interface acq_sequencer_if #(
    parameter int unsigned REG_ADDR_WIDTH = 8,
    parameter int unsigned REG_DATA_WIDTH = 16
);
    logic [REG_ADDR_WIDTH-1:0] register_addr;
    logic [REG_DATA_WIDTH-1:0] register_data;
    logic                      register_rdy;

    modport master (output register_addr, output register_data, output register_rdy);
    modport slave  (input  register_addr, input  register_data, input  register_rdy);
endinterface

// File: rtl/acq_sequencer_timer.sv
// acq_timer: loadable down-counter with clear and enable; tc_o flags the
// enabled cycle in which the count sits at zero, once per load.
module acq_timer #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc_o
);
    logic [WIDTH-1:0] count_q;
    logic             expired_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q   <= '0;
            expired_q <= 1'b1;
        end else if (load) begin
            count_q   <= load_val;
            expired_q <= 1'b0;
        end else if (en) begin
            if (count_q != '0)
                count_q <= count_q - WIDTH'(1);
            else
                expired_q <= 1'b1;
        end
    end

    // Saturates at zero: expired_q suppresses any repeat terminal count.
    assign tc_o = en && !expired_q && (count_q == '0);
endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: control-register write -> arm, wait trigger, channel A/B
// readout, optional continuous re-arm. ACQ_HOLDOFF_EN adds a holdoff register/state.
module acq_sequencer
    import acq_sequencer_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH   = 8,
    parameter int unsigned REG_DATA_WIDTH   = 16,
    parameter int unsigned ADDR_ACQ_CTRL    = ADDR_ACQ_CTRL_DEF,
    parameter int unsigned DEFAULT_ACQ_CTRL = DEFAULT_ACQ_CTRL_DEF,
    parameter int unsigned ADDR_HOLDOFF     = ADDR_HOLDOFF_DEF,
    parameter int unsigned DEFAULT_HOLDOFF  = DEFAULT_HOLDOFF_DEF,
    parameter int unsigned TIMEOUT_WIDTH    = 24,
    parameter int unsigned AUTO_TIMEOUT     = AUTO_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    acq_sequencer_if.slave        reg_bus,
    input  logic                  trigger_done_i,
    input  logic                  chA_done_i,
    input  logic                  chB_done_i,
    output logic                  start_o,
    output logic                  stop_o,
    output logic                  force_trigger_o,
    output logic                  rqst_chA_o,
    output logic                  rqst_chB_o,
    output logic                  busy_o,
    output logic [2:0]            state_o
);
    acq_state_e            state_q, state_d;
    logic [CTRL_BITS-1:0]  ctrl_q, ctrl_eff;
    logic                  ctrl_wr, abort, clr_run;
    logic                  cha_sh, chb_sh, auto_sh;
    logic                  start_d, stop_d, force_d, rqa_d, rqb_d;
    logic                  tmo_load, tmo_en, tmo_tc;
    logic                  unused_bits;

    assign ctrl_wr  = reg_bus.register_rdy &&
                      (reg_bus.register_addr == REG_ADDR_WIDTH'(ADDR_ACQ_CTRL));
    assign ctrl_eff = ctrl_wr ? reg_bus.register_data[CTRL_BITS-1:0] : ctrl_q;
    assign abort    = ctrl_wr && !reg_bus.register_data[CTRL_RUN] && (state_q != IDLE);
    assign unused_bits = ^reg_bus.register_data[REG_DATA_WIDTH-1:CTRL_BITS];

    acq_timer #(.WIDTH(TIMEOUT_WIDTH)) u_timeout (
        .clk(clk), .rst(rst), .clr(abort), .load(tmo_load),
        .load_val(TIMEOUT_WIDTH'(AUTO_TIMEOUT - 1)), .en(tmo_en), .tc_o(tmo_tc)
    );

`ifdef ACQ_HOLDOFF_EN
    logic [REG_DATA_WIDTH-1:0] holdoff_q, ho_load_val;
    logic                      ho_wr, ho_load, ho_en, ho_tc;

    assign ho_wr = reg_bus.register_rdy &&
                   (reg_bus.register_addr == REG_ADDR_WIDTH'(ADDR_HOLDOFF));
    // Loaded with holdoff-1 so HOLDOFF lasts exactly holdoff cycles (minimum one).
    assign ho_load_val = (holdoff_q == '0) ? '0 : holdoff_q - REG_DATA_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst)
            holdoff_q <= REG_DATA_WIDTH'(DEFAULT_HOLDOFF);
        else if (ho_wr)
            holdoff_q <= reg_bus.register_data;
    end

    acq_timer #(.WIDTH(REG_DATA_WIDTH)) u_holdoff (
        .clk(clk), .rst(rst), .clr(abort), .load(ho_load),
        .load_val(ho_load_val), .en(ho_en), .tc_o(ho_tc)
    );
`else
    logic unused_holdoff;
    assign unused_holdoff = ^{32'(ADDR_HOLDOFF), 32'(DEFAULT_HOLDOFF)};
`endif

    always_comb begin
        state_d  = state_q;
        force_d  = 1'b0;
        stop_d   = 1'b0;
        clr_run  = 1'b0;
        tmo_load = 1'b0;
        tmo_en   = 1'b0;
`ifdef ACQ_HOLDOFF_EN
        ho_load  = 1'b0;
        ho_en    = 1'b0;
`endif
        case (state_q)
            IDLE:      if (ctrl_eff[CTRL_RUN]) state_d = ARM;
            ARM: begin
                state_d  = WAIT_TRIG;
                tmo_load = 1'b1;
            end
            WAIT_TRIG: begin
                tmo_en = auto_sh;
                if (trigger_done_i)
                    state_d = cha_sh ? XFER_A : (chb_sh ? XFER_B : DONE);
                else if (tmo_tc)
                    force_d = 1'b1;
            end
            XFER_A:    if (chA_done_i) state_d = chb_sh ? XFER_B : DONE;
            XFER_B:    if (chB_done_i) state_d = DONE;
            DONE: begin
                if (ctrl_eff[CTRL_CONT] && ctrl_eff[CTRL_RUN]) begin
`ifdef ACQ_HOLDOFF_EN
                    state_d = HOLDOFF;
                    ho_load = 1'b1;
`else
                    state_d = ARM;
`endif
                end else begin
                    state_d = IDLE;
                    clr_run = 1'b1;
                end
            end
`ifdef ACQ_HOLDOFF_EN
            HOLDOFF: begin
                ho_en = 1'b1;
                if (ho_tc) state_d = ARM;
            end
`endif
            default:   state_d = IDLE;
        endcase

        // Abort write takes priority over any same-cycle trigger/done/timeout.
        if (abort) begin
            state_d = IDLE;
            stop_d  = 1'b1;
            force_d = 1'b0;
        end

        start_d = (state_d == ARM);
        rqa_d   = (state_d == XFER_A) && (state_q != XFER_A);
        rqb_d   = (state_d == XFER_B) && (state_q != XFER_B);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            ctrl_q          <= CTRL_BITS'(DEFAULT_ACQ_CTRL);
            cha_sh          <= 1'b0;
            chb_sh          <= 1'b0;
            auto_sh         <= 1'b0;
            start_o         <= 1'b0;
            stop_o          <= 1'b0;
            force_trigger_o <= 1'b0;
            rqst_chA_o      <= 1'b0;
            rqst_chB_o      <= 1'b0;
            busy_o          <= 1'b0;
        end else begin
            state_q         <= state_d;
            start_o         <= start_d;
            stop_o          <= stop_d;
            force_trigger_o <= force_d;
            rqst_chA_o      <= rqa_d;
            rqst_chB_o      <= rqb_d;
            busy_o          <= (state_d != IDLE);
            if (ctrl_wr)
                ctrl_q <= reg_bus.register_data[CTRL_BITS-1:0];
            else if (clr_run)
                ctrl_q[CTRL_RUN] <= 1'b0;
            if (state_q == ARM) begin
                cha_sh  <= ctrl_eff[CTRL_CHA];
                chb_sh  <= ctrl_eff[CTRL_CHB];
                auto_sh <= ctrl_eff[CTRL_AUTO];
            end
        end
    end

    assign state_o = state_q;
endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: expected output pulses are queued with
// their cycle as stimulus is driven and matched as the DUT emits them.
module tb_acq_sequencer;
    import acq_sequencer_pkg::*;

    localparam int AT = 50;
    localparam int K_START = 0, K_STOP = 1, K_FORCE = 2, K_RQA = 3, K_RQB = 4;
`ifdef ACQ_HOLDOFF_EN
    localparam int HO_DEF = 1;
    localparam int HO_20  = 20;
`else
    localparam int HO_DEF = 0;
    localparam int HO_20  = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trigger_done_i = 1'b0, chA_done_i = 1'b0, chB_done_i = 1'b0;
    logic       start_o, stop_o, force_trigger_o, rqst_chA_o, rqst_chB_o, busy_o;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    acq_sequencer_if #(.REG_ADDR_WIDTH(8), .REG_DATA_WIDTH(16)) bus ();

    acq_sequencer #(.AUTO_TIMEOUT(AT)) dut (
        .clk(clk), .rst(rst), .reg_bus(bus),
        .trigger_done_i(trigger_done_i), .chA_done_i(chA_done_i), .chB_done_i(chB_done_i),
        .start_o(start_o), .stop_o(stop_o), .force_trigger_o(force_trigger_o),
        .rqst_chA_o(rqst_chA_o), .rqst_chB_o(rqst_chB_o),
        .busy_o(busy_o), .state_o(state_o)
    );

    typedef struct { int kind; int at; } ev_t;
    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [4:0] mon_p;
    int         cyc = 0;
    int         total = 0, bad = 0;
    int         n, t, d, a;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int k, input int at);
        ev_t e;
        e.kind = k;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int cnt);
        for (int i = 0; i < cnt; i++) tick();
    endtask

    task automatic wr(input int addr, input int data);
        bus.register_rdy  = 1'b1;
        bus.register_addr = 8'(addr);
        bus.register_data = 16'(data);
        tick();
        bus.register_rdy  = 1'b0;
    endtask

    task automatic pulse_trig();
        trigger_done_i = 1'b1; tick(); trigger_done_i = 1'b0;
    endtask

    task automatic pulse_a();
        chA_done_i = 1'b1; tick(); chA_done_i = 1'b0;
    endtask

    task automatic pulse_b();
        chB_done_i = 1'b1; tick(); chB_done_i = 1'b0;
    endtask

    always @(negedge clk) begin
        mon_p = {rqst_chB_o, rqst_chA_o, force_trigger_o, stop_o, start_o};
        for (int k = 0; k < 5; k++) begin
            if (mon_p[k] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse_kind", k, -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_kind", k, mon_e.kind);
                    check("pulse_cycle", cyc, mon_e.at);
                end
            end
        end
    end

    initial begin
        bus.register_rdy  = 1'b0;
        bus.register_addr = '0;
        bus.register_data = '0;
        ticks(2);
        rst = 1'b0;
        check("rst_start", int'(start_o), 0);
        check("rst_stop", int'(stop_o), 0);
        check("rst_force", int'(force_trigger_o), 0);
        check("rst_rqa", int'(rqst_chA_o), 0);
        check("rst_rqb", int'(rqst_chB_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_state", int'(state_o), int'(IDLE));
        tick();

        // single mode, both channels
        n = cyc; expect_ev(K_START, n + 1);
        wr(16, 'h19);
        check("single_arm", int'(state_o), int'(ARM));
        check("single_busy", int'(busy_o), 1);
        ticks(3);
        t = cyc; expect_ev(K_RQA, t + 1);
        pulse_trig();
        check("single_xfer_a", int'(state_o), int'(XFER_A));
        ticks(3);
        d = cyc; expect_ev(K_RQB, d + 1);
        pulse_a();
        check("single_xfer_b", int'(state_o), int'(XFER_B));
        ticks(2);
        pulse_b();
        check("single_done", int'(state_o), int'(DONE));
        tick();
        check("single_idle", int'(state_o), int'(IDLE));
        check("single_busy_low", int'(busy_o), 0);
        check("single_run_cleared", int'(dut.ctrl_q[CTRL_RUN]), 0);

        // continuous mode, channel A only, three rounds then abort
        n = cyc; expect_ev(K_START, n + 1);
        wr(16, 'h0B);
        tick();
        for (int r = 0; r < 3; r++) begin
            ticks(2);
            t = cyc; expect_ev(K_RQA, t + 1);
            pulse_trig();
            tick();
            d = cyc; expect_ev(K_START, d + 2 + HO_DEF);
            pulse_a();
            ticks(HO_DEF + 2);
            check("cont_wait_trig", int'(state_o), int'(WAIT_TRIG));
        end
        a = cyc; expect_ev(K_STOP, a + 1);
        wr(16, 'h00);
        check("cont_abort_idle", int'(state_o), int'(IDLE));
        check("cont_abort_busy", int'(busy_o), 0);
        tick();

        // auto timeout: force pulse exactly once, then normal readout
        n = cyc; expect_ev(K_START, n + 1); expect_ev(K_FORCE, n + 2 + AT);
        wr(16, 'h0D);
        ticks(n + 2 + AT + 10 - cyc);
        check("auto_still_waiting", int'(state_o), int'(WAIT_TRIG));
        t = cyc; expect_ev(K_RQA, t + 1);
        pulse_trig();
        ticks(2);
        pulse_a();
        tick();
        check("auto_idle", int'(state_o), int'(IDLE));

        // trigger in the same cycle as the timeout: no force pulse
        n = cyc; expect_ev(K_START, n + 1);
        wr(16, 'h0D);
        ticks(n + 1 + AT - cyc);
        t = cyc; expect_ev(K_RQA, t + 1);
        pulse_trig();
        check("race_xfer_a", int'(state_o), int'(XFER_A));
        ticks(2);
        pulse_a();
        tick();
        check("race_idle", int'(state_o), int'(IDLE));

        // abort write coinciding with chA_done in XFER_A
        n = cyc; expect_ev(K_START, n + 1);
        wr(16, 'h19);
        ticks(2);
        t = cyc; expect_ev(K_RQA, t + 1);
        pulse_trig();
        ticks(2);
        a = cyc; expect_ev(K_STOP, a + 1);
        bus.register_rdy = 1'b1; bus.register_addr = 8'd16; bus.register_data = '0;
        chA_done_i = 1'b1;
        tick();
        bus.register_rdy = 1'b0; chA_done_i = 1'b0;
        check("abort_idle", int'(state_o), int'(IDLE));
        ticks(3);
        check("abort_stays_idle", int'(state_o), int'(IDLE));

        // reset while in WAIT_TRIG
        n = cyc; expect_ev(K_START, n + 1);
        wr(16, 'h19);
        ticks(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_start", int'(start_o), 0);
        check("mrst_stop", int'(stop_o), 0);
        check("mrst_rqa", int'(rqst_chA_o), 0);
        check("mrst_busy", int'(busy_o), 0);
        check("mrst_state", int'(state_o), int'(IDLE));
        ticks(2);
        check("mrst_stays_idle", int'(state_o), int'(IDLE));

        // holdoff register = 20, continuous
        wr(17, 20);
        n = cyc; expect_ev(K_START, n + 1);
        wr(16, 'h0B);
        ticks(2);
        t = cyc; expect_ev(K_RQA, t + 1);
        pulse_trig();
        tick();
        d = cyc; expect_ev(K_START, d + 2 + HO_20);
        pulse_a();
        check("ho_done", int'(state_o), int'(DONE));
        ticks(HO_20 + 3);
        check("ho_wait_trig", int'(state_o), int'(WAIT_TRIG));
        a = cyc; expect_ev(K_STOP, a + 1);
        wr(16, 'h00);
        check("ho_abort_idle", int'(state_o), int'(IDLE));

        ticks(5);
        check("exp_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
